hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates per-stage stall/flush enables and E-stage forwarding selects.
- Sequences multi-cycle data-memory waits with a timeout, plus halt drain and halted state.
- Sits beside the datapath and drives its pipeline-register enables and clears directly.

---
 rtl/hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage F/D/E/M/W core.
// Drives stage stall/flush enables, E-stage forwarding selects,
// data-memory wait sequencing with timeout, and halt drain/halted.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ra1D/ra2D, ra1E/ra2E source registers in D and E
//   rdE/rdM/rdW         destination registers in E/M/W
//   mem_to_regE         E holds a load
//   reg_writeM/W        M/W write the register file
//   pc_srcE, jumpE      redirect resolved in E
//   hltD, hltW          halt instruction in D / W
//   mem_reqM, mem_ready data-memory request in M / completion
//   stallF..stallM      hold pipeline registers
//   flushD/E/W          clear F2D / D2E / M2W registers
//   forwardAE/BE        00 regfile, 01 resultW, 10 alu_outM
//   halted, mem_err     core halted / sticky memory timeout
//   stall_cnt, flush_cnt, memwait_cnt  performance counters
//
// Optional: define HAZARD_PERF_EN to build saturating performance
// counters; otherwise the counter ports are tied to zero.

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ra1D,
    input  logic [4:0]       ra2D,
    input  logic [4:0]       ra1E,
    input  logic [4:0]       ra2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             mem_to_regE,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic             pc_srcE,
    input  logic             jumpE,
    input  logic             hltD,
    input  logic             hltW,
    input  logic             mem_reqM,
    input  logic             mem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              memErrNext;
    logic              mw;
    logic              ctrlChange;
    logic              loadUse;

    function automatic logic [1:0] fwdSel(input logic [4:0] ra);
        if (reg_writeM && rdM != 5'd0 && rdM == ra)
            return 2'b10;
        else if (reg_writeW && rdW != 5'd0 && rdW == ra)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forwardAE = fwdSel(ra1E);
    assign forwardBE = fwdSel(ra2E);

    // Waits are honoured while draining too; only HALTED ignores them.
    assign mw = (state != HALTED) & mem_reqM & ~mem_ready;

    assign ctrlChange = pc_srcE | jumpE;
    assign loadUse = mem_to_regE & (rdE != 5'd0)
                   & ((rdE == ra1D) | (rdE == ra2D));

    assign halted = (state == HALTED);

    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushW      = 1'b0;
        stateNext   = state;
        waitCntNext = waitCnt;
        memErrNext  = mem_err;
        unique case (state)
            HALTED: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end
            default: begin
                if (mw) begin
                    // M holds; W gets a bubble while the access is pending.
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    stallM = 1'b1;
                    flushW = 1'b1;
                    if (waitCnt == WAIT_LAST) begin
                        stateNext  = HALTED;
                        memErrNext = 1'b1;
                    end else begin
                        waitCntNext = waitCnt + WAIT_W'(1);
                        if (state == RUN)
                            stateNext = MEM_WAIT;
                    end
                end else begin
                    waitCntNext = '0;
                    if (state == DRAIN) begin
                        stallF = 1'b1;
                        flushD = 1'b1;
                        if (hltW)
                            stateNext = HALTED;
                    end else begin
                        // The completing MEM_WAIT cycle acts like RUN so a
                        // halt held in D during the wait is not lost.
                        stateNext = RUN;
                        if (ctrlChange) begin
                            flushD = 1'b1;
                            flushE = 1'b1;
                        end else if (loadUse) begin
                            stallF = 1'b1;
                            stallD = 1'b1;
                            flushE = 1'b1;
                        end else if (hltD) begin
                            stateNext = DRAIN;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            mem_err <= memErrNext;
        end
    end

`ifdef HAZARD_PERF_EN
    logic countEn;
    logic ctrlFlush;

    assign countEn   = (state != HALTED);
    assign ctrlFlush = countEn & ~mw & (state != DRAIN) & ctrlChange;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else if (countEn) begin
            if (stallF && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ctrlFlush && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (mw && !(&memwait_cnt))
                memwait_cnt <= memwait_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl
// against a behavioural model of the pipeline-control rules.

module tb_hazard_ctrl;

    localparam int TO = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW;
    logic          mem_to_regE, reg_writeM, reg_writeW;
    logic          pc_srcE, jumpE, hltD, hltW, mem_reqM, mem_ready;
    logic          stallF, stallD, stallE, stallM;
    logic          flushD, flushE, flushW;
    logic [1:0]    forwardAE, forwardBE;
    logic          halted, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

    int checks = 0;
    int failures = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .mem_to_regE(mem_to_regE),
        .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .pc_srcE(pc_srcE), .jumpE(jumpE),
        .hltD(hltD), .hltW(hltW),
        .mem_reqM(mem_reqM), .mem_ready(mem_ready),
        .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: halted/draining flags, consecutive wait count.
    bit            mHalted = 0;
    bit            mDrain = 0;
    bit            mErr = 0;
    int            mRun = 0;
    logic [CW-1:0] mStall = '0;
    logic [CW-1:0] mFlush = '0;
    logic [CW-1:0] mWait = '0;

    function automatic logic [1:0] fwdRef(input logic [4:0] ra);
        if (ra == 0) return 2'b00;
        if (reg_writeM && rdM == ra) return 2'b10;
        if (reg_writeW && rdW == ra) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit mwRef();
        return !mHalted && mem_reqM && !mem_ready;
    endfunction

    function automatic bit luRef();
        return mem_to_regE && rdE != 0 && (rdE == ra1D || rdE == ra2D);
    endfunction

    function automatic bit ctlRef();
        return pc_srcE || jumpE;
    endfunction

    // {stallF,D,E,M, flushD,E,W, fwdA, fwdB, halted, mem_err}
    function automatic logic [12:0] expOut();
        logic [6:0] c;
        if (mHalted || mwRef()) c = 7'b1111_001;
        else if (mDrain) c = 7'b1000_100;
        else if (ctlRef()) c = 7'b0000_110;
        else if (luRef()) c = 7'b1100_010;
        else c = 7'b0;
        return {c, fwdRef(ra1E), fwdRef(ra2E), mHalted, mErr};
    endfunction

    function automatic logic [12:0] dutOut();
        return {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                forwardAE, forwardBE, halted, mem_err};
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (&v) ? v : v + 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mHalted = 0; mDrain = 0; mErr = 0; mRun = 0;
            mStall = '0; mFlush = '0; mWait = '0;
        end else if (!mHalted) begin
`ifdef HAZARD_PERF_EN
            if (expOut()[12]) mStall = sat(mStall);
            if (!mwRef() && !mDrain && ctlRef()) mFlush = sat(mFlush);
            if (mwRef()) mWait = sat(mWait);
`endif
            if (mwRef()) begin
                mRun++;
                if (mRun == TO) begin
                    mHalted = 1;
                    mErr = 1;
                end
            end else begin
                mRun = 0;
                if (mDrain) begin
                    if (hltW) mHalted = 1;
                end else if (hltD && !ctlRef() && !luRef()) begin
                    mDrain = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleIn();
        ra1D = 0; ra2D = 0; ra1E = 0; ra2E = 0;
        rdE = 0; rdM = 0; rdW = 0;
        mem_to_regE = 0; reg_writeM = 0; reg_writeW = 0;
        pc_srcE = 0; jumpE = 0; hltD = 0; hltW = 0;
        mem_reqM = 0; mem_ready = 0;
    endtask

    task automatic doReset();
        reset = 1;
        idleIn();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idleIn();
        tick();
        #1;
        checks++;
        if (dutOut() !== 13'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b exp %b", dutOut(), 13'b0);
        end
        checks++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d %0d %0d exp 0",
                     stall_cnt, flush_cnt, memwait_cnt);
        end
        reset = 0;
    endtask

    task automatic test_forward();
        idleIn();
        reg_writeM = 1; rdM = 5; reg_writeW = 1; rdW = 5;
        ra1E = 5; ra2E = 5;
        #1;
        checks++;
        if ({forwardAE, forwardBE} !== 4'b1010) begin
            failures++;
            $display("FAIL fwd_m_over_w: got %b %b exp 10 10",
                     forwardAE, forwardBE);
        end
        rdM = 0;
        #1;
        checks++;
        if ({forwardAE, forwardBE} !== 4'b0101) begin
            failures++;
            $display("FAIL fwd_w: got %b %b exp 01 01", forwardAE, forwardBE);
        end
        reg_writeW = 0;
        #1;
        checks++;
        if ({forwardAE, forwardBE} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_none: got %b %b exp 00 00",
                     forwardAE, forwardBE);
        end
        for (int i = 0; i < 60; i++) begin
            rdM = 5'($urandom_range(0, 3));
            rdW = 5'($urandom_range(0, 3));
            ra1E = 5'($urandom_range(0, 3));
            ra2E = 5'($urandom_range(0, 3));
            reg_writeM = 1'($urandom);
            reg_writeW = 1'($urandom);
            #1;
            checks++;
            if ({forwardAE, forwardBE} !== {fwdRef(ra1E), fwdRef(ra2E)}) begin
                failures++;
                $display("FAIL fwd_rand: got %b %b exp %b %b", forwardAE,
                         forwardBE, fwdRef(ra1E), fwdRef(ra2E));
            end
        end
        idleIn();
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        mem_to_regE = 1; rdE = 3; ra2D = 3;
        #1;
        checks++;
        if (dutOut()[12:6] !== 7'b1100_010) begin
            failures++;
            $display("FAIL lu_stall: got %b exp 1100010", dutOut()[12:6]);
        end
        tick();
        mem_to_regE = 0; rdE = 0;
        #1;
        checks++;
        if (dutOut()[12:6] !== 7'b0) begin
            failures++;
            $display("FAIL lu_one_bubble: got %b exp 0000000",
                     dutOut()[12:6]);
        end
        mem_to_regE = 1; rdE = 3; pc_srcE = 1;
        #1;
        checks++;
        if (dutOut()[12:6] !== 7'b0000_110) begin
            failures++;
            $display("FAIL lu_vs_branch: got %b exp 0000110", dutOut()[12:6]);
        end
        tick();
        idleIn();
        tick();
    endtask

    task automatic test_mem_wait();
        doReset();
        mem_reqM = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dutOut()[12:6] !== 7'b1111_001) begin
                failures++;
                $display("FAIL memwait_cyc%0d: got %b exp 1111001",
                         i, dutOut()[12:6]);
            end
            tick();
        end
        mem_ready = 1;
        #1;
        checks++;
        if (dutOut() !== 13'b0) begin
            failures++;
            $display("FAIL memwait_done: got %b exp 0", dutOut());
        end
        tick();
        idleIn();
        #1;
        checks++;
        if (dutOut() !== expOut() || dutOut() !== 13'b0) begin
            failures++;
            $display("FAIL memwait_resume: got %b exp 0", dutOut());
        end
        checks++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== {mStall, mFlush, mWait}) begin
            failures++;
            $display("FAIL memwait_cnt: got %0d %0d %0d exp %0d %0d %0d",
                     stall_cnt, flush_cnt, memwait_cnt, mStall, mFlush, mWait);
        end
    endtask

    task automatic test_timeout();
        doReset();
        mem_reqM = 1; mem_ready = 0;
        for (int i = 0; i < TO; i++) begin
            #1;
            checks++;
            if (halted !== 1'b0 || mem_err !== 1'b0 || stallM !== 1'b1) begin
                failures++;
                $display("FAIL timeout_wait%0d: got h=%b e=%b sM=%b exp 0 0 1",
                         i, halted, mem_err, stallM);
            end
            tick();
        end
        idleIn();
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dutOut() !== 13'b1111_001_0000_11) begin
                failures++;
                $display("FAIL timeout_halted%0d: got %b exp %b",
                         i, dutOut(), 13'b1111_001_0000_11);
            end
            tick();
        end
        checks++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== {mStall, mFlush, mWait}) begin
            failures++;
            $display("FAIL timeout_cnt: got %0d %0d %0d exp %0d %0d %0d",
                     stall_cnt, flush_cnt, memwait_cnt, mStall, mFlush, mWait);
        end
    endtask

    task automatic test_halt_drain();
        doReset();
        hltD = 1;
        #1;
        checks++;
        if (dutOut() !== 13'b0) begin
            failures++;
            $display("FAIL halt_take: got %b exp 0", dutOut());
        end
        tick();
        hltD = 0;
        for (int i = 1; i <= 3; i++) begin
            hltW = (i == 3);
            #1;
            checks++;
            if (dutOut() !== 13'b1000_100_0000_00) begin
                failures++;
                $display("FAIL drain_cyc%0d: got %b exp %b",
                         i, dutOut(), 13'b1000_100_0000_00);
            end
            tick();
        end
        hltW = 0;
        #1;
        checks++;
        if (dutOut() !== 13'b1111_001_0000_10) begin
            failures++;
            $display("FAIL drain_halted: got %b exp %b",
                     dutOut(), 13'b1111_001_0000_10);
        end
        doReset();
        hltD = 1; jumpE = 1;
        #1;
        checks++;
        if (dutOut()[12:6] !== 7'b0000_110) begin
            failures++;
            $display("FAIL halt_squash: got %b exp 0000110", dutOut()[12:6]);
        end
        tick();
        idleIn();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (dutOut() !== 13'b0) begin
                failures++;
                $display("FAIL halt_squash_run%0d: got %b exp 0", i, dutOut());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        mem_reqM = 1;
        tick();
        tick();
        reset = 1;
        idleIn();
        tick();
        reset = 0;
        #1;
        checks++;
        if (dutOut() !== 13'b0) begin
            failures++;
            $display("FAIL reset_memwait: got %b exp 0", dutOut());
        end
        checks++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_memwait_cnt: got %0d %0d %0d exp 0",
                     stall_cnt, flush_cnt, memwait_cnt);
        end
        hltD = 1;
        tick();
        hltD = 0;
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if (dutOut() !== 13'b0) begin
            failures++;
            $display("FAIL reset_drain: got %b exp 0", dutOut());
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 1500; i++) begin
            ra1D = 5'($urandom_range(0, 3));
            ra2D = 5'($urandom_range(0, 3));
            ra1E = 5'($urandom_range(0, 3));
            ra2E = 5'($urandom_range(0, 3));
            rdE = 5'($urandom_range(0, 3));
            rdM = 5'($urandom_range(0, 3));
            rdW = 5'($urandom_range(0, 3));
            mem_to_regE = ($urandom_range(0, 2) == 0);
            reg_writeM = 1'($urandom);
            reg_writeW = 1'($urandom);
            pc_srcE = ($urandom_range(0, 7) == 0);
            jumpE = ($urandom_range(0, 15) == 0);
            hltD = ($urandom_range(0, 19) == 0);
            hltW = ($urandom_range(0, 3) == 0);
            mem_reqM = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 3) == 0);
            reset = (mHalted && $urandom_range(0, 3) == 0)
                 || ($urandom_range(0, 199) == 0);
            #1;
            checks++;
            if (dutOut() !== expOut()) begin
                failures++;
                $display("FAIL rand_out cyc%0d: got %b exp %b",
                         i, dutOut(), expOut());
            end
            checks++;
            if ({stall_cnt, flush_cnt, memwait_cnt} !== {mStall, mFlush, mWait}) begin
                failures++;
                $display("FAIL rand_cnt cyc%0d: got %0d %0d %0d exp %0d %0d %0d",
                         i, stall_cnt, flush_cnt, memwait_cnt,
                         mStall, mFlush, mWait);
            end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idleIn();
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_halt_drain();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
